// File: rtl/id_stage.sv
// RV32I decode stage: register file with write-first reads, instruction decode,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        is_valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        is_flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  output logic        is_stall,
  output logic        is_valid,
  output logic [31:0] pc,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        is_branch,
  output logic        is_jump,
  output logic        alu_src_imm,
  output logic        is_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [2:0]  f3;
  logic [31:0] d_imm, d_rs1_data, d_rs2_data;
  logic [3:0]  d_alu_op;
  logic        writes_rd, uses_rs1, uses_rs2;
  logic        d_mem_re, d_mem_we, d_branch, d_jump, d_src_imm, d_illegal;
  logic        bubble;

  assign opcode = instr_in[6:0];
  assign rd_f   = instr_in[11:7];
  assign f3     = instr_in[14:12];
  assign rs1_f  = instr_in[19:15];
  assign rs2_f  = instr_in[24:20];

  // instr[30] only distinguishes SUB for register ops; shifts use it for both forms
  function automatic logic [3:0] alu_fn(input logic [2:0] fn, input logic alt, input logic reg_op);
    case (fn)
      3'b000:  alu_fn = (alt && reg_op) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Write-first bypass so a same-cycle write-back is seen by decode
  always_comb begin
    d_rs1_data = rf[rs1_f];
    d_rs2_data = rf[rs2_f];
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs1_f) d_rs1_data = wb_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs2_f) d_rs2_data = wb_data;
    if (rs1_f == 5'd0) d_rs1_data = '0;
    if (rs2_f == 5'd0) d_rs2_data = '0;
  end

  always_comb begin
    d_imm     = '0;
    d_alu_op  = ALU_ADD;
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    d_mem_re  = 1'b0;
    d_mem_we  = 1'b0;
    d_branch  = 1'b0;
    d_jump    = 1'b0;
    d_src_imm = 1'b0;
    d_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        d_alu_op  = alu_fn(f3, instr_in[30], 1'b1);
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OP_I: begin
        d_imm     = {{20{instr_in[31]}}, instr_in[31:20]};
        d_alu_op  = alu_fn(f3, instr_in[30], 1'b0);
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        d_src_imm = 1'b1;
      end
      OP_LOAD: begin
        d_imm     = {{20{instr_in[31]}}, instr_in[31:20]};
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        d_mem_re  = 1'b1;
        d_src_imm = 1'b1;
      end
      OP_STORE: begin
        d_imm     = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        d_mem_we  = 1'b1;
        d_src_imm = 1'b1;
      end
      OP_BRANCH: begin
        d_imm     = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
        d_alu_op  = ALU_SUB;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        d_branch  = 1'b1;
      end
      OP_JAL: begin
        d_imm     = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
        writes_rd = 1'b1;
        d_jump    = 1'b1;
        d_src_imm = 1'b1;
      end
      OP_JALR: begin
        d_imm     = {{20{instr_in[31]}}, instr_in[31:20]};
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        d_jump    = 1'b1;
        d_src_imm = 1'b1;
      end
      OP_LUI: begin
        d_imm     = {instr_in[31:12], 12'b0};
        d_alu_op  = ALU_PASSB;
        writes_rd = 1'b1;
        d_src_imm = 1'b1;
      end
      OP_AUIPC: begin
        d_imm     = {instr_in[31:12], 12'b0};
        writes_rd = 1'b1;
        d_src_imm = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Flush wins over the load-use stall; reset also masks the request
  assign is_stall = reset_n && is_valid_in && !is_flush && ex_is_load && (ex_rd != 5'd0) &&
                    ((uses_rs1 && ex_rd == rs1_f) || (uses_rs2 && ex_rd == rs2_f));
  assign bubble = !is_valid_in || is_flush || is_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_valid    <= 1'b0;
      pc          <= '0;
      rs1_data    <= '0;
      rs2_data    <= '0;
      imm         <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      funct3      <= '0;
      alu_op      <= '0;
      reg_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      is_branch   <= 1'b0;
      is_jump     <= 1'b0;
      alu_src_imm <= 1'b0;
      is_illegal  <= 1'b0;
    end else begin
      pc          <= pc_in;
      rs1_data    <= d_rs1_data;
      rs2_data    <= d_rs2_data;
      imm         <= d_imm;
      rs1         <= rs1_f;
      rs2         <= rs2_f;
      funct3      <= f3;
      alu_op      <= d_alu_op;
      is_valid    <= !bubble;
      rd          <= (!bubble && writes_rd) ? rd_f : 5'd0;
      reg_we      <= !bubble && writes_rd && (rd_f != 5'd0);
      mem_re      <= !bubble && d_mem_re;
      mem_we      <= !bubble && d_mem_we;
      is_branch   <= !bubble && d_branch;
      is_jump     <= !bubble && d_jump;
      alu_src_imm <= !bubble && d_src_imm;
      is_illegal  <= !bubble && d_illegal;
    end
  end

endmodule
